// File: rtl/iot_event_arbiter_pkg.sv
// Shared types and sizing helpers for the IoT event arbiter.
// Imported by the arbiter core and its round-robin picker.
package iot_event_arbiter_pkg;

    localparam int N_DEV_DEFAULT = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEFAULT = id_width(N_DEV_DEFAULT);

    typedef logic [N_DEV_DEFAULT-1:0] dev_mask_t;
    typedef logic [ID_W_DEFAULT-1:0]  dev_id_t;

endpackage

// File: rtl/iot_event_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or
// after ptr, wrapping modulo N_DEV.
module rr_arbiter
    import iot_event_arbiter_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT,
    parameter int ID_W  = id_width(N_DEV)
) (
    input  logic [N_DEV-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id
);

    int idx;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int k = N_DEV - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_DEV;
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/iot_event_arbiter.sv
// Captures per-device connect/disconnect events, drops redundant
// ones and serialises real changes into one pulse per clock.
module iot_event_arbiter
    import iot_event_arbiter_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT,
    parameter int ID_W  = id_width(N_DEV),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] ev_valid,
    input  logic [N_DEV-1:0] ev_on,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic [N_DEV-1:0] active_map,
    output logic [N_DEV-1:0] pend_map,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [N_DEV-1:0] pend_q, pend_d;
    logic [N_DEV-1:0] dir_q, dir_d;
    logic [N_DEV-1:0] act_q, act_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             change_q, change_d;
    logic             on_off_q, on_off_d;
    logic [ID_W-1:0]  dev_id_q, dev_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic             gnt_valid;
    logic [ID_W-1:0]  gnt_id;
    logic [N_DEV-1:0] gnt_oh;
    logic [N_DEV-1:0] ovr;
    logic             real_chg;
    int               n_ovr;
    int               drop_sum;

    rr_arbiter #(
        .N_DEV (N_DEV),
        .ID_W  (ID_W)
    ) u_rr (
        .req       (pend_q),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        gnt_oh = '0;
        if (gnt_valid) begin
            gnt_oh[gnt_id] = 1'b1;
        end
    end

    // A new event on the granted device is a fresh entry, not a drop.
    assign ovr = ev_valid & pend_q & ~gnt_oh;

    assign real_chg = gnt_valid && (dir_q[gnt_id] != act_q[gnt_id]);

    always_comb begin
        pend_d = pend_q;
        dir_d  = dir_q;
        for (int i = 0; i < N_DEV; i++) begin
            if (gnt_oh[i]) begin
                pend_d[i] = 1'b0;
            end
            if (ev_valid[i]) begin
                pend_d[i] = 1'b1;
                dir_d[i]  = ev_on[i];
            end
        end
    end

    always_comb begin
        n_ovr = 0;
        for (int i = 0; i < N_DEV; i++) begin
            n_ovr = n_ovr + int'(ovr[i]);
        end
        drop_sum = int'(drop_q) + n_ovr;
        if (drop_sum > CNT_MAX) begin
            drop_d = CNT_W'(CNT_MAX);
        end else begin
            drop_d = CNT_W'(drop_sum);
        end
    end

    always_comb begin
        act_d    = act_q;
        change_d = 1'b0;
        on_off_d = on_off_q;
        dev_id_d = dev_id_q;
        if (real_chg) begin
            act_d[gnt_id] = dir_q[gnt_id];
            change_d      = 1'b1;
            on_off_d      = dir_q[gnt_id];
            dev_id_d      = gnt_id;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) begin
            if (int'(gnt_id) == N_DEV - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            dir_q    <= '0;
            act_q    <= '0;
            drop_q   <= '0;
            change_q <= 1'b0;
            on_off_q <= 1'b0;
            dev_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            act_q    <= act_d;
            drop_q   <= drop_d;
            change_q <= change_d;
            on_off_q <= on_off_d;
            dev_id_q <= dev_id_d;
            ptr_q    <= ptr_d;
        end
    end

    assign change     = change_q;
    assign on_off     = on_off_q;
    assign dev_id     = dev_id_q;
    assign active_map = act_q;
    assign pend_map   = pend_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Directed vector table plus hand-written corner sequences
// for the IoT event arbiter.
module tb_iot_event_arbiter;
    import iot_event_arbiter_pkg::*;

    typedef struct {
        logic       rst;
        logic [7:0] v;
        logic [7:0] on;
        logic       chg;
        logic       oo;
        logic [2:0] id;
        logic [7:0] act;
        logic [7:0] pend;
        logic [7:0] drop;
    } vec_t;

    logic      clk;
    logic      rst;
    dev_mask_t ev_valid;
    dev_mask_t ev_on;
    logic      change;
    logic      on_off;
    dev_id_t   dev_id;
    dev_mask_t active_map;
    dev_mask_t pend_map;
    logic [7:0] drop_cnt;

    int n_vec;
    int n_bad;
    vec_t tbl[$];

    iot_event_arbiter #(
        .N_DEV (8),
        .ID_W  (3),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ev_valid   (ev_valid),
        .ev_on      (ev_on),
        .change     (change),
        .on_off     (on_off),
        .dev_id     (dev_id),
        .active_map (active_map),
        .pend_map   (pend_map),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [7:0] v,
                        input logic [7:0] o);
        rst      = r;
        ev_valid = v;
        ev_on    = o;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] v,
                       input logic [7:0] o, input logic c,
                       input logic oo, input logic [2:0] id,
                       input logic [7:0] act, input logic [7:0] pend,
                       input logic [7:0] drop);
        vec_t e;
        e.rst = r; e.v = v; e.on = o; e.chg = c; e.oo = oo;
        e.id = id; e.act = act; e.pend = pend; e.drop = drop;
        tbl.push_back(e);
    endtask

    initial begin
        int pulses;
        int exp_drop;
        logic [28:0] got;
        logic [28:0] exp;
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        ev_valid = '0;
        ev_on = '0;

        // reset with ev_valid ignored, then idle
        add(1, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 0);
        add(1, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 0);
        add(0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
        // single connect on dev 3
        add(0, 8'h08, 8'h08, 0, 0, 0, 8'h00, 8'h08, 0);
        add(0, 8'h00, 8'h00, 1, 1, 3, 8'h08, 8'h00, 0);
        add(0, 8'h00, 8'h00, 0, 1, 3, 8'h08, 8'h00, 0);
        // reset so burst starts at ptr 0
        add(1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
        add(0, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, 8'hFF, 0);
        for (int k = 0; k < 8; k++) begin
            add(0, 8'h00, 8'h00, 1, 1, 3'(k),
                8'((32'd1 << (k + 1)) - 1),
                8'(32'hFF << (k + 1)), 0);
        end
        add(0, 8'h00, 8'h00, 0, 1, 7, 8'hFF, 8'h00, 0);
        // redundant connect on dev 2
        add(0, 8'h04, 8'h04, 0, 1, 7, 8'hFF, 8'h04, 0);
        add(0, 8'h00, 8'h00, 0, 1, 7, 8'hFF, 8'h00, 0);
        add(0, 8'h00, 8'h00, 0, 1, 7, 8'hFF, 8'h00, 0);

        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].v, tbl[k].on);
            got = {change, on_off, dev_id, active_map, pend_map,
                   drop_cnt};
            exp = {tbl[k].chg, tbl[k].oo, tbl[k].id, tbl[k].act,
                   tbl[k].pend, tbl[k].drop};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL row%0d: got chg=%b oo=%b id=%0d act=%h pend=%h drop=%0d expected chg=%b oo=%b id=%0d act=%h pend=%h drop=%0d",
                         k, change, on_off, dev_id, active_map,
                         pend_map, drop_cnt, tbl[k].chg, tbl[k].oo,
                         tbl[k].id, tbl[k].act, tbl[k].pend,
                         tbl[k].drop);
            end
        end

        // overwrite dev 5 while 0..4 pending
        step(1, 8'h00, 8'h00);
        step(0, 8'h3F, 8'h3F);
        chk("ovr_pend", 32'(pend_map), 32'h3F);
        step(0, 8'h20, 8'h00);
        chk("ovr_first", {change, on_off, dev_id}, {1'b1, 1'b1, 3'd0});
        chk("ovr_drop", 32'(drop_cnt), 1);
        chk("ovr_pend2", 32'(pend_map), 32'h3E);
        for (int e = 0; e < 4; e++) begin
            step(0, 8'h00, 8'h00);
            chk("ovr_seq", {change, on_off, dev_id},
                {1'b1, 1'b1, 3'(e + 1)});
        end
        step(0, 8'h00, 8'h00);
        chk("ovr_dev5", {change, on_off, dev_id}, {1'b0, 1'b1, 3'd4});
        chk("ovr_act", 32'(active_map), 32'h1F);
        chk("ovr_end", {pend_map, drop_cnt}, {8'h00, 8'd1});

        // grant/recapture collision on dev 1
        step(1, 8'h00, 8'h00);
        step(0, 8'h02, 8'h02);
        step(0, 8'h02, 8'h00);
        chk("col_on", {change, on_off, dev_id}, {1'b1, 1'b1, 3'd1});
        chk("col_maps", {active_map, pend_map, drop_cnt},
            {8'h02, 8'h02, 8'd0});
        step(0, 8'h00, 8'h00);
        chk("col_off", {change, on_off, dev_id}, {1'b1, 1'b0, 3'd1});
        chk("col_maps2", {active_map, pend_map, drop_cnt},
            {8'h00, 8'h00, 8'd0});

        // reset mid-burst
        step(1, 8'h00, 8'h00);
        step(0, 8'hFF, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            step(0, 8'h00, 8'h00);
            chk("mid_pulse", {change, dev_id}, {1'b1, 3'(k)});
        end
        step(1, 8'hFF, 8'hFF);
        chk("mid_rst", {change, on_off, dev_id, active_map, pend_map,
                        drop_cnt}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 8'h00, 8'h00);
            if (change) pulses++;
        end
        chk("mid_quiet", 32'(pulses), 0);
        chk("mid_maps", {active_map, pend_map}, 32'd0);

        // drop counter saturation: dev 0/1 always re-firing
        step(1, 8'h00, 8'h00);
        step(0, 8'h03, 8'h03);
        chk("sat_start", 32'(drop_cnt), 0);
        exp_drop = 0;
        for (int k = 1; k <= 300; k++) begin
            step(0, 8'h03, (k % 2 == 1) ? 8'h00 : 8'h03);
            exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
            if (k == 100 || k == 254 || k == 255 || k == 300) begin
                chk("sat_drop", 32'(drop_cnt), 32'(exp_drop));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
